// File: rtl/serial_full_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : serial_full_adder
//  Description : Multi-cycle adder/subtractor. A single DIGIT-bit ripple
//                slice is reused LSB-first over WIDTH/DIGIT clock cycles,
//                with the carry (or borrow) held in a flop between digits.
//
//  Ports
//    clk       in   clock, all state changes on the rising edge
//    rst       in   synchronous active-high reset
//    start     in   request a new operation, sampled only while busy=0
//    mode      in   0 = add, 1 = subtract (latched with the operands)
//    carryin   in   carry-in (add) / borrow-in (subtract), latched
//    x, y      in   WIDTH-bit operands, latched on an accepted start
//    sum       out  WIDTH-bit registered result, held until next completion
//    carryout  out  registered carry-out (add) / borrow-out (subtract)
//    busy      out  high while an operation is in flight
//    done      out  one-cycle pulse when sum/carryout are updated
//
//  Revision    : 1.0  initial release
// ============================================================================
module serial_full_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             carryin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             busy,
    output logic             done
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_full_adder: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    localparam int                 c_num_digits = WIDTH / DIGIT;
    localparam int                 c_cnt_w      = (c_num_digits > 1) ? $clog2(c_num_digits) : 1;
    localparam logic [c_cnt_w-1:0] c_last_digit = c_cnt_w'(c_num_digits - 1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_xs;      // operand A, doubles as the result shift register
    logic [WIDTH-1:0]   r_ys;      // operand B, shifted right one digit per cycle
    logic               r_mode;
    logic               r_carry;   // internal carry between digits
    logic [c_cnt_w-1:0] r_cnt;

    // ------------------------------------------------------------------------
    // DIGIT-bit ripple slice. Subtraction feeds ~y into the slice; the
    // inversion of carryin is applied once, when the carry flop is loaded.
    // ------------------------------------------------------------------------
    logic [DIGIT-1:0] w_a;
    logic [DIGIT-1:0] w_b;
    logic [DIGIT-1:0] w_s;
    logic [DIGIT:0]   w_c;

    assign w_a    = r_xs[DIGIT-1:0];
    assign w_b    = r_ys[DIGIT-1:0] ^ {DIGIT{r_mode}};
    assign w_c[0] = r_carry;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_fa
            assign w_s[gi]   = w_a[gi] ^ w_b[gi] ^ w_c[gi];
            assign w_c[gi+1] = (w_a[gi] & w_b[gi]) | (w_c[gi] & (w_a[gi] ^ w_b[gi]));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Shift paths. Result digits enter r_xs from the top as operand digits
    // leave from the bottom, so after N digits r_xs holds the full result.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_xs_next;
    logic [WIDTH-1:0] w_ys_next;

    generate
        if (WIDTH == DIGIT) begin : g_single_digit
            assign w_xs_next = w_s;
            assign w_ys_next = '0;
        end else begin : g_multi_digit
            assign w_xs_next = {w_s, r_xs[WIDTH-1:DIGIT]};
            assign w_ys_next = {{DIGIT{1'b0}}, r_ys[WIDTH-1:DIGIT]};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_xs     <= '0;
            r_ys     <= '0;
            r_mode   <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            sum      <= '0;
            carryout <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_xs    <= x;
                        r_ys    <= y;
                        r_mode  <= mode;
                        // subtract runs as x + ~y + ~borrow_in
                        r_carry <= carryin ^ mode;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    r_xs    <= w_xs_next;
                    r_ys    <= w_ys_next;
                    r_carry <= w_c[DIGIT];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_last_digit) begin
                        sum      <= w_xs_next;
                        // borrow is the inverted final carry
                        carryout <= w_c[DIGIT] ^ r_mode;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_full_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_serial_full_adder
//  Description : Self-checking bench for serial_full_adder. Stimulus pushes
//                expected results into per-DUT queues; monitors pop and
//                compare whenever a DUT pulses done.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst      = 1'b1;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic rst_seen = 1'b0;
    logic mon_en   = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Main DUT: WIDTH=8, DIGIT=1
    // ------------------------------------------------------------------------
    logic       s8_start = 1'b0, s8_mode = 1'b0, s8_cin = 1'b0;
    logic [7:0] s8_x = '0, s8_y = '0;
    logic [7:0] s8_sum;
    logic       s8_co, s8_busy, s8_done;

    serial_full_adder #(.WIDTH(8), .DIGIT(1)) u_dut (
        .clk(clk), .rst(rst), .start(s8_start), .mode(s8_mode), .carryin(s8_cin),
        .x(s8_x), .y(s8_y), .sum(s8_sum), .carryout(s8_co), .busy(s8_busy), .done(s8_done)
    );

    logic [8:0] q8_val[$];
    int         q8_edge[$];
    logic [7:0] hold_sum = '0;
    logic       hold_co  = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_seen) begin
                chk("rst_sum", 32'(s8_sum), 32'h0);
                chk("rst_carryout", 32'(s8_co), 32'h0);
                chk("rst_busy", 32'(s8_busy), 32'h0);
                chk("rst_done", 32'(s8_done), 32'h0);
                q8_val.delete();
                q8_edge.delete();
                hold_sum = '0;
                hold_co  = 1'b0;
            end else if (s8_done) begin
                if (q8_val.size() == 0) begin
                    chk("unexpected_done", 32'(s8_done), 32'h0);
                end else begin
                    logic [8:0] e;
                    int         ed;
                    e  = q8_val.pop_front();
                    ed = q8_edge.pop_front();
                    chk("sum8", 32'(s8_sum), 32'(e[7:0]));
                    chk("carryout8", 32'(s8_co), 32'(e[8]));
                    chk("latency8", 32'(cyc), 32'(ed + 8));
                    hold_sum = e[7:0];
                    hold_co  = e[8];
                end
            end else begin
                chk("hold_sum8", 32'(s8_sum), 32'(hold_sum));
                chk("hold_carryout8", 32'(s8_co), 32'(hold_co));
            end
        end
    end

    task automatic issue8(input logic [7:0] xv, input logic [7:0] yv, input logic mv, input logic cv,
                          input logic [7:0] es, input logic eco, input bit accept);
        s8_x = xv; s8_y = yv; s8_mode = mv; s8_cin = cv; s8_start = 1'b1;
        if (accept) begin
            q8_val.push_back({eco, es});
            q8_edge.push_back(cyc + 1);
        end
        @(negedge clk);
        s8_start = 1'b0;
    endtask

    task automatic wait_done8(input string nm);
        int t;
        t = 0;
        while (s8_done !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (s8_done !== 1'b1) chk({nm, "_timeout"}, 32'(s8_done), 32'h1);
    endtask

    // ------------------------------------------------------------------------
    // Second DUT: WIDTH=8, DIGIT=4
    // ------------------------------------------------------------------------
    logic       s84_start = 1'b0, s84_mode = 1'b0, s84_cin = 1'b0;
    logic [7:0] s84_x = '0, s84_y = '0;
    logic [7:0] s84_sum;
    logic       s84_co, s84_busy, s84_done;

    serial_full_adder #(.WIDTH(8), .DIGIT(4)) u_dut84 (
        .clk(clk), .rst(rst), .start(s84_start), .mode(s84_mode), .carryin(s84_cin),
        .x(s84_x), .y(s84_y), .sum(s84_sum), .carryout(s84_co), .busy(s84_busy), .done(s84_done)
    );

    logic [8:0] q84_val[$];
    int         q84_edge[$];

    always @(negedge clk) begin
        if (mon_en && !rst_seen && s84_done) begin
            if (q84_val.size() == 0) begin
                chk("unexpected_done84", 32'(s84_done), 32'h0);
            end else begin
                logic [8:0] e;
                int         ed;
                e  = q84_val.pop_front();
                ed = q84_edge.pop_front();
                chk("sum84", 32'(s84_sum), 32'(e[7:0]));
                chk("carryout84", 32'(s84_co), 32'(e[8]));
                chk("latency84", 32'(cyc), 32'(ed + 2));
            end
        end
    end

    task automatic run84(input logic [7:0] xv, input logic [7:0] yv, input logic mv, input logic cv,
                         input logic [7:0] es, input logic eco);
        int t;
        s84_x = xv; s84_y = yv; s84_mode = mv; s84_cin = cv; s84_start = 1'b1;
        q84_val.push_back({eco, es});
        q84_edge.push_back(cyc + 1);
        @(negedge clk);
        s84_start = 1'b0;
        t = 0;
        while (s84_done !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (s84_done !== 1'b1) chk("done84_timeout", 32'(s84_done), 32'h1);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    // Exhaustive WIDTH=4 DUTs for DIGIT = 1, 2, 4
    // ------------------------------------------------------------------------
    bit w4_go      = 1'b0;
    int w4_fin_cnt = 0;

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_w4
        localparam int D = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
        localparam int N = 4 / D;

        logic       st = 1'b0, md = 1'b0, ci = 1'b0;
        logic [3:0] xa = '0, yb = '0;
        logic [3:0] sm;
        logic       co, bz, dn;
        logic [4:0] qv[$];
        int         qe[$];

        serial_full_adder #(.WIDTH(4), .DIGIT(D)) u_dut4 (
            .clk(clk), .rst(rst), .start(st), .mode(md), .carryin(ci),
            .x(xa), .y(yb), .sum(sm), .carryout(co), .busy(bz), .done(dn)
        );

        always @(negedge clk) begin
            if (mon_en && !rst_seen && dn) begin
                if (qv.size() == 0) begin
                    chk("w4_unexpected_done", 32'(dn), 32'h0);
                end else begin
                    logic [4:0] e;
                    int         ed;
                    e  = qv.pop_front();
                    ed = qe.pop_front();
                    chk("w4_sum", 32'(sm), 32'(e[3:0]));
                    chk("w4_carryout", 32'(co), 32'(e[4]));
                    chk("w4_latency", 32'(cyc), 32'(ed + N));
                end
            end
        end

        initial begin
            wait (w4_go);
            @(negedge clk);
            for (int v = 0; v < 1024; v++) begin
                logic [3:0] a, b;
                logic       c, m;
                logic [4:0] e;
                int         r, t;
                a = v[3:0]; b = v[7:4]; c = v[8]; m = v[9];
                if (!m) begin
                    r = int'(a) + int'(b) + int'(c);
                    e = r[4:0];
                end else begin
                    r = int'(a) - int'(b) - int'(c);
                    e = {(int'(a) < int'(b) + int'(c)), r[3:0]};
                end
                xa = a; yb = b; ci = c; md = m; st = 1'b1;
                qv.push_back(e);
                qe.push_back(cyc + 1);
                @(negedge clk);
                st = 1'b0;
                xa = 4'($urandom); yb = 4'($urandom); ci = 1'($urandom); md = 1'($urandom);
                t = 0;
                while (dn !== 1'b1 && t < N + 4) begin
                    @(negedge clk);
                    xa = 4'($urandom); yb = 4'($urandom); ci = 1'($urandom); md = 1'($urandom);
                    t++;
                end
                if (dn !== 1'b1) begin
                    chk("w4_timeout", 32'(dn), 32'h1);
                    break;
                end
            end
            w4_fin_cnt++;
        end
    end

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int t;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // add overflow, busy for exactly 8 cycles
        issue8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("busy_first", 32'(s8_busy), 32'h1);
        repeat (7) begin
            @(negedge clk);
            chk("busy_run", 32'(s8_busy), 32'h1);
            chk("done_early", 32'(s8_done), 32'h0);
        end
        @(negedge clk);
        chk("busy_end", 32'(s8_busy), 32'h0);
        chk("done_pulse", 32'(s8_done), 32'h1);
        @(negedge clk);
        chk("done_one_cycle", 32'(s8_done), 32'h0);

        // subtract with and without borrow
        issue8(8'h05, 8'h07, 1'b1, 1'b1, 8'hFD, 1'b1, 1'b1);
        wait_done8("sub_borrow");
        @(negedge clk);
        issue8(8'h07, 8'h05, 1'b1, 1'b0, 8'h02, 1'b0, 1'b1);
        wait_done8("sub_noborrow");
        @(negedge clk);

        // ignored start while busy, then back-to-back start in the done cycle
        issue8(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b1);
        @(negedge clk);
        issue8(8'h0F, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        wait_done8("ignored_start");
        issue8(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b1);
        wait_done8("back_to_back");
        // boundary vectors issued back to back
        issue8(8'h80, 8'h80, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1);
        wait_done8("add_carry_all");
        issue8(8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
        wait_done8("sub_zero_borrow");
        issue8(8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        wait_done8("sub_equal");
        @(negedge clk);

        // reset in the middle of a run: no done may follow
        issue8(8'h33, 8'h11, 1'b0, 1'b0, 8'h44, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("post_reset_busy", 32'(s8_busy), 32'h0);
        issue8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b1);
        wait_done8("after_reset");
        @(negedge clk);

        // DIGIT=4 instance
        run84(8'hAB, 8'h55, 1'b0, 1'b1, 8'h01, 1'b1);
        run84(8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b0);
        run84(8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b1);

        // exhaustive WIDTH=4 runs in parallel
        w4_go = 1'b1;
        t = 0;
        while (w4_fin_cnt < 3 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("w4_all_finished", 32'(w4_fin_cnt), 32'h3);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
